// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-side bus of the memory access controller.
// slave is the controller's view; master is the surrounding requester plus memory.
interface mem_access_ctrl_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADWIDTH = 32
);
  logic                 valid;
  logic                 rw;
  logic [ADWIDTH-1:0]   addr_in;
  logic [WIDTH-1:0]     wdata;
  logic [WIDTH/8-1:0]   be;
  logic                 ready;
  logic                 done;
  logic                 err;
  logic [WIDTH-1:0]     rdata;
  logic [ADWIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic [WIDTH/8-1:0]   mem_be;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [WIDTH-1:0]     mem_rdata;

  modport slave (
    input  valid, rw, addr_in, wdata, be, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_be, mem_rd_en, mem_wr_en
  );

  modport master (
    output valid, rw, addr_in, wdata, be, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_be, mem_rd_en, mem_wr_en
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller: accepts one aligned read/write,
// holds the memory enable for WAIT_CYCLES cycles, then reports done/err.
module mem_access_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADWIDTH     = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);
  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned CNTW  = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [ADWIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]     mem_be_q, mem_be_d;
  logic                 misaligned_c;

  // Any set byte-offset bit makes the request misaligned (never true for WIDTH=8).
  assign misaligned_c = (bus.addr_in & ADWIDTH'(BYTES - 1)) != '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    done_d      = done_q;
    err_d       = err_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          ready_d     = 1'b0;
          mem_addr_d  = bus.addr_in >> OFFW;
          mem_wdata_d = bus.wdata;
          mem_be_d    = bus.rw ? '1 : bus.be;
          if (misaligned_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNTW'(WAIT_CYCLES);
            rd_en_d = bus.rw;
            wr_en_d = !bus.rw;
          end
        end
      end
      ACCESS: begin
        // The edge that ends the last enable cycle also captures read data.
        if (cnt_q <= CNTW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          if (rd_en_q) rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        if (!bus.valid) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized traffic on a
// 32-bit/2-wait instance checked every cycle against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int unsigned W_A = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   rdata_rand = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.WIDTH(32), .ADWIDTH(32)) bus_a ();
  mem_access_ctrl_if #(.WIDTH(64), .ADWIDTH(32)) bus_b ();

  mem_access_ctrl #(.WIDTH(32), .ADWIDTH(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mem_access_ctrl #(.WIDTH(64), .ADWIDTH(32), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory read data: fixed for directed reads, random every cycle otherwise.
  always @(negedge clk) bus_a.mem_rdata = rdata_rand ? 32'($urandom) : 32'hDEADBEEF;

  // Transaction-level model of instance A, indexed by clock-edge number.
  int unsigned k = 0, acc_k = 0, done_k = 0;
  bit          live = 0, busy = 0, m_rw = 0, m_mis = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_be = '0;

  always begin
    @(posedge clk);
    k++;
    if (reset) begin
      live = 1; busy = 0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0;
    end else if (live) begin
      if (!busy) begin
        if (bus_a.valid) begin
          busy    = 1;
          acc_k   = k;
          m_rw    = bus_a.rw;
          m_mis   = (bus_a.addr_in % 4) != 0;
          m_addr  = bus_a.addr_in / 4;
          m_wdata = bus_a.wdata;
          m_be    = bus_a.rw ? 4'hF : bus_a.be;
          done_k  = acc_k + (m_mis ? 0 : W_A);
        end
      end else begin
        if (!m_mis && m_rw && k == acc_k + W_A) m_rdata = bus_a.mem_rdata;
        if (k > done_k && !bus_a.valid) busy = 0;
      end
    end
    #1;
    if (live) begin
      bit en_win;
      en_win = busy && !m_mis && k >= acc_k && k < acc_k + W_A;
      chk("cyc_ready", 64'(bus_a.ready), 64'(!busy));
      chk("cyc_done", 64'(bus_a.done), 64'(busy && k >= done_k));
      chk("cyc_err", 64'(bus_a.err), 64'(busy && k >= done_k && m_mis));
      chk("cyc_rd_en", 64'(bus_a.mem_rd_en), 64'(en_win && m_rw));
      chk("cyc_wr_en", 64'(bus_a.mem_wr_en), 64'(en_win && !m_rw));
      chk("cyc_mem_addr", 64'(bus_a.mem_addr), 64'(m_addr));
      chk("cyc_mem_wdata", 64'(bus_a.mem_wdata), 64'(m_wdata));
      chk("cyc_mem_be", 64'(bus_a.mem_be), 64'(m_be));
      chk("cyc_rdata", 64'(bus_a.rdata), 64'(m_rdata));
    end
  end

  // One request on A: wait for done (bounded), hold valid, then release.
  task automatic req_a(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int hold, input bit scramble,
                       input bit abort, output int lat, output int nrd,
                       output int nwr, output int hold_bad, output logic e);
    lat = 0; nrd = 0; nwr = 0; hold_bad = 0; e = 1'b0;
    bus_a.valid = 1'b1; bus_a.rw = r; bus_a.addr_in = a; bus_a.wdata = d; bus_a.be = b;
    forever begin
      @(negedge clk);
      lat++;
      nrd += int'(bus_a.mem_rd_en);
      nwr += int'(bus_a.mem_wr_en);
      if (bus_a.done) break;
      if (abort && lat == 1) begin
        reset = 1'b1; bus_a.valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (lat >= 40) begin
        n_tests++; n_fail++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        break;
      end
      if (scramble) begin
        bus_a.rw = 1'($urandom); bus_a.addr_in = $urandom;
        bus_a.wdata = $urandom; bus_a.be = 4'($urandom);
      end
    end
    e = bus_a.err;
    repeat (hold) begin
      @(negedge clk);
      if (!bus_a.done || bus_a.ready || bus_a.mem_rd_en || bus_a.mem_wr_en) hold_bad++;
      if (scramble) begin
        bus_a.rw = 1'($urandom); bus_a.addr_in = $urandom;
      end
    end
    bus_a.valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, nrd, nwr, hb, done_seen;
    logic e;
    logic [31:0] a;
    bus_a.valid = 1'b0; bus_a.rw = 1'b0; bus_a.addr_in = '0; bus_a.wdata = '0; bus_a.be = '0;
    bus_b.valid = 1'b0; bus_b.rw = 1'b0; bus_b.addr_in = '0; bus_b.wdata = '0; bus_b.be = '0;
    bus_b.mem_rdata = 64'h0123456789ABCDEF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 64'(bus_a.ready), 64'd1);
    chk("rst_done", 64'(bus_a.done), 64'd0);
    chk("rst_mem_be", 64'(bus_a.mem_be), 64'd0);
    chk("rst_rdata", 64'(bus_a.rdata), 64'd0);

    req_a(1'b1, 32'h10, 32'h0, 4'h0, 0, 0, 0, lat, nrd, nwr, hb, e);
    chk("rd_mem_addr", 64'(bus_a.mem_addr), 64'h4);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_en_cycles", 64'(nrd), 64'd2);
    chk("rd_wr_cycles", 64'(nwr), 64'd0);
    chk("rd_rdata", 64'(bus_a.rdata), 64'hDEADBEEF);
    chk("rd_err", 64'(e), 64'd0);

    req_a(1'b0, 32'h20, 32'h12345678, 4'b0011, 0, 0, 0, lat, nrd, nwr, hb, e);
    chk("wr_mem_addr", 64'(bus_a.mem_addr), 64'h8);
    chk("wr_en_cycles", 64'(nwr), 64'd2);
    chk("wr_mem_be", 64'(bus_a.mem_be), 64'h3);
    chk("wr_mem_wdata", 64'(bus_a.mem_wdata), 64'h12345678);
    chk("wr_latency", 64'(lat), 64'd3);

    req_a(1'b1, 32'h13, 32'h0, 4'hF, 0, 0, 0, lat, nrd, nwr, hb, e);
    chk("mis_latency", 64'(lat), 64'd1);
    chk("mis_err", 64'(e), 64'd1);
    chk("mis_enables", 64'(nrd + nwr), 64'd0);

    req_a(1'b1, 32'h40, 32'h0, 4'h0, 5, 1, 0, lat, nrd, nwr, hb, e);
    chk("hold_bad_cycles", 64'(hb), 64'd0);
    chk("hold_ready_after", 64'(bus_a.ready), 64'd1);
    chk("hold_rd_cycles", 64'(nrd), 64'd2);

    req_a(1'b1, 32'h30, 32'h0, 4'h0, 0, 0, 1, lat, nrd, nwr, hb, e);
    chk("abort_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
    chk("abort_ready", 64'(bus_a.ready), 64'd1);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      done_seen += int'(bus_a.done);
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    // 64-bit, single-wait instance
    bus_b.valid = 1'b1; bus_b.rw = 1'b1; bus_b.addr_in = 32'h18;
    lat = 0; nrd = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      nrd += int'(bus_b.mem_rd_en);
      if (bus_b.done) break;
    end
    chk("b_mem_addr", 64'(bus_b.mem_addr), 64'h3);
    chk("b_latency", 64'(lat), 64'd2);
    chk("b_rd_cycles", 64'(nrd), 64'd1);
    chk("b_rdata", bus_b.rdata, 64'h0123456789ABCDEF);
    bus_b.valid = 1'b0;
    @(negedge clk);
    chk("b_ready_after", 64'(bus_b.ready), 64'd1);

    rdata_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      req_a(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(3)), 1,
            $urandom_range(9) == 0, lat, nrd, nwr, hb, e);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
